// File: rtl/offset_cmd_issuer_pkg.sv
// Shared definitions for the offset-driven command issuer: default widths,
// outstanding-counter width and the job FSM state type.
package offset_cmd_issuer_pkg;

  localparam int unsigned ADDR_W_DEF = 64;
  localparam int unsigned CNT_W_DEF  = 32;

  // 9 bits so that 255 outstanding plus one more cannot wrap.
  localparam int unsigned OUT_W = 9;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
    ST_DONE
  } state_e;

endpackage

// File: rtl/offset_cmd_issuer_credit.sv
// credit_counter: tracks commands issued but not yet completed.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   clear        : zero the count (new job)
//   inc, dec     : one issue / one completion this cycle
//   limit        : outstanding-command ceiling
//   count        : current outstanding count
//   below_limit  : count < limit
//   underflow    : dec requested while count is zero (completion dropped)
module credit_counter
  import offset_cmd_issuer_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             inc,
  input  logic             dec,
  input  logic [7:0]       limit,
  output logic [OUT_W-1:0] count,
  output logic             below_limit,
  output logic             underflow
);

  logic dec_ok;

  assign dec_ok      = dec && (count != '0);
  assign underflow   = dec && (count == '0);
  assign below_limit = count < {1'b0, limit};

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count <= '0;
    end else begin
      case ({inc, dec_ok})
        2'b10:   count <= count + OUT_W'(1);
        2'b01:   count <= count - OUT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/offset_cmd_issuer.sv
// offset_cmd_issuer: issues io_total commands of io_len bytes at
// base + io_offset, keeping at most io_max_out outstanding, then waits for
// all completions and pulses io_done.
//   clock, reset           : rising-edge clock, synchronous active-high reset
//   io_start + job fields  : job request (base, total, len, max_out)
//   io_offset/io_offset_en : offset generator value and advance request
//   io_cmd_*               : command valid/ready handshake, addr, len
//   io_resp_valid          : one completion per asserted cycle
//   io_busy/done/err       : status; io_issued counts accepted commands
module offset_cmd_issuer
  import offset_cmd_issuer_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              io_start,
  input  logic [ADDR_W-1:0] io_base_addr,
  input  logic [CNT_W-1:0]  io_total,
  input  logic [CNT_W-1:0]  io_len,
  input  logic [7:0]        io_max_out,
  input  logic [31:0]       io_offset,
  output logic              io_offset_en,
  output logic              io_cmd_valid,
  input  logic              io_cmd_ready,
  output logic [ADDR_W-1:0] io_cmd_addr,
  output logic [CNT_W-1:0]  io_cmd_len,
  input  logic              io_resp_valid,
  output logic              io_busy,
  output logic              io_done,
  output logic              io_err,
  output logic [CNT_W-1:0]  io_issued
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] base_q;
  logic [CNT_W-1:0]  total_q, len_q, issued_q;
  logic [7:0]        max_q;
  logic              err_q;

  logic             start_ok, cmd_valid, fire, busy, done;
  logic [OUT_W-1:0] out_count;
  logic             below_limit, underflow;

  credit_counter u_credit (
    .clock       (clock),
    .reset       (reset),
    .clear       (start_ok),
    .inc         (fire),
    .dec         (io_resp_valid),
    .limit       (max_q),
    .count       (out_count),
    .below_limit (below_limit),
    .underflow   (underflow)
  );

  always_ff @(posedge clock) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    start_ok  = 1'b0;
    cmd_valid = 1'b0;
    fire      = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (io_start && !reset) begin
          start_ok = 1'b1;
          state_d  = (io_total == '0) ? ST_DONE : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        busy      = 1'b1;
        cmd_valid = below_limit && !reset;
        fire      = cmd_valid && io_cmd_ready;
        if (fire && (issued_q == total_q - CNT_W'(1))) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        busy = 1'b1;
        // A response that retires the last outstanding command finishes now.
        if ((out_count == '0) || ((out_count == OUT_W'(1)) && io_resp_valid))
          state_d = ST_DONE;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      base_q   <= '0;
      total_q  <= '0;
      len_q    <= '0;
      max_q    <= '0;
      issued_q <= '0;
      err_q    <= 1'b0;
    end else if (start_ok) begin
      base_q   <= io_base_addr;
      total_q  <= io_total;
      len_q    <= io_len;
      max_q    <= (io_max_out == '0) ? 8'd1 : io_max_out;
      issued_q <= '0;
      err_q    <= 1'b0;
    end else begin
      if (fire)      issued_q <= issued_q + CNT_W'(1);
      if (underflow) err_q    <= 1'b1;
    end
  end

  assign io_cmd_valid = cmd_valid;
  assign io_offset_en = fire;
  assign io_busy      = busy && !reset;
  assign io_done      = done && !reset;
  assign io_err       = err_q && !reset;
  assign io_issued    = reset ? '0 : issued_q;
  assign io_cmd_addr  = base_q + ADDR_W'(io_offset);
  assign io_cmd_len   = len_q;

endmodule
